// File: rtl/riscv32_dmem_responder_if.sv
// riscv32_dmem_responder_if
// Request/response channels between the riscv32 load/store port (master)
// and the data-memory responder (slave). Both channels use valid/ready.
interface riscv32_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv32_dmem_responder.sv
// riscv32_dmem_responder
// Multi-cycle data-memory slave for the riscv32 load/store port. One request
// at a time, WAIT_CYCLES wait states, byte/half/word access to a word RAM,
// extended load data returned on a valid/ready response channel.
// Optional build macro: RISCV32_DMEM_MISALIGN_TRAP_EN turns misaligned
// H/HU/SH/W/SW accesses into errors instead of forcing them aligned.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched; counts wait states, commits the access on exit
// RESP  | rsp_valid high, response held until rsp_ready
module riscv32_dmem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  riscv32_dmem_responder_if.slave   bus,
  output logic                      busy
);

  localparam int         LP_DEPTH = 1 << MEM_WORDS_LOG2;
  localparam int         LP_ABITS = MEM_WORDS_LOG2 + 2;
  localparam logic [3:0] LP_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_we;
  logic [LP_ABITS-1:0]  r_addr;
  logic [2:0]           r_f3;
  logic [31:0]          r_wdata;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_busy;

  logic [31:0]          r_mem [0:LP_DEPTH-1];

  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic [31:0]               w_word;
  logic                      w_legal;
  logic                      w_misalign;
  logic                      w_commit;
  logic                      w_wr_en;
  logic [3:0]                w_be;
  logic [31:0]               w_wlane;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [31:0]               w_load_data;

  assign w_idx  = r_addr[LP_ABITS-1:2];
  assign w_word = r_mem[w_idx];

  // Legal funct3 set: loads allow B/H/W/BU/HU, stores only B/H/W.
  always_comb begin
    w_legal = 1'b0;
    case (r_f3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~r_we;
      default:                w_legal = 1'b0;
    endcase
  end

`ifdef RISCV32_DMEM_MISALIGN_TRAP_EN
  // Misaligned half/word accesses trap instead of touching memory.
  always_comb begin
    w_misalign = 1'b0;
    case (r_f3[1:0])
      2'b01:   w_misalign = r_addr[0];
      2'b10:   w_misalign = |r_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  // Misaligned accesses are forced aligned by the lane selection below.
  assign w_misalign = 1'b0;
`endif

  // The access happens on the edge that leaves WAIT for RESP.
  assign w_commit = (r_state == ST_WAIT) && (r_cnt == LP_WAIT);
  assign w_wr_en  = w_commit && r_we && w_legal && !w_misalign;

  // Byte enables and lane-replicated store data; half/word ignore low bits.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = 32'h0;
    case (r_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    w_byte = 8'h0;
    case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half      = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load_data = 32'h0;
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      3'b010:  w_load_data = w_word;
      default: w_load_data = 32'h0;
    endcase
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_f3        <= 3'b000;
      r_wdata     <= 32'h0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr[LP_ABITS-1:0];
            r_f3        <= bus.req_funct3;
            r_wdata     <= bus.req_wdata;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == LP_WAIT) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            if (!w_legal || w_misalign) begin
              r_rsp_rdata <= 32'h0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_rsp_rdata <= r_we ? 32'h0 : w_load_data;
              r_rsp_err   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = r_busy;

endmodule
